// File: rtl/mmio_ram_v2_pkg.sv
// Shared address-map helpers and read-source encoding for mmio_ram_v2.
package mmio_ram_v2_pkg;

    localparam int unsigned OFS_PRESCALE = 0;
    localparam int unsigned OFS_IN_BASE  = 1;

    typedef enum logic [2:0] {
        SRC_RAM,
        SRC_PRESCALE,
        SRC_IN,
        SRC_EDGE,
        SRC_IRQEN
    } src_e;

    function automatic int unsigned top_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    function automatic int unsigned ofs_edge(input int unsigned n_in);
        return OFS_IN_BASE + n_in;
    endfunction

    function automatic int unsigned ofs_irqen(input int unsigned n_in);
        return OFS_IN_BASE + n_in + 1;
    endfunction

endpackage

// File: rtl/mmio_ram_v2_ram.sv
// Single-port synchronous RAM, write-first, with enable and no reset.
module ram_sp #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              mem_clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge mem_clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= di;
                dout      <= di;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mmio_ram_v2.sv
// Data memory with an MMIO window at the top of the address space:
// prescaler, synchronised input ports, sticky edge flags and a maskable irq.
module mmio_ram_v2
    import mmio_ram_v2_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int N_IN      = 3,
    parameter int EDGE_PORT = N_IN - 1
) (
    input  logic                   mem_clk,
    input  logic                   mem_reset,
    input  logic                   read,
    input  logic                   write,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      mem_di,
    input  logic [N_IN*DATA_W-1:0] in_bus,
    output logic [DATA_W-1:0]      mem_do,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      mm_prescale,
    output logic                   irq
);

    localparam int unsigned TOP = top_addr(ADDR_W);
    localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(TOP - OFS_PRESCALE);
    localparam logic [ADDR_W-1:0] A_EDGE     = ADDR_W'(TOP - ofs_edge(N_IN));
    localparam logic [ADDR_W-1:0] A_IRQEN    = ADDR_W'(TOP - ofs_irqen(N_IN));

    logic [N_IN*DATA_W-1:0] sync1, sync2;
    logic [DATA_W-1:0]      btn_prev, edge_q, irq_en, rise;
    logic [DATA_W-1:0]      mmio_val, mmio_q, hold_q, ram_dout;
    src_e                   src, src_q;
    logic                   rd_acc, is_mmio, ram_we, ram_en;

    assign rd_acc  = read & ~write;
    // IRQ_EN is the lowest MMIO address; everything above it is shadowed.
    assign is_mmio = (address >= A_IRQEN);
    assign ram_we  = write & ~is_mmio;
    assign ram_en  = ram_we | rd_acc;
    assign rise    = sync2[EDGE_PORT*DATA_W +: DATA_W] & ~btn_prev;

    ram_sp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .mem_clk(mem_clk),
        .en     (ram_en),
        .we     (ram_we),
        .addr   (address),
        .di     (mem_di),
        .dout   (ram_dout)
    );

    always_comb begin
        src      = SRC_RAM;
        mmio_val = '0;
        if (address == A_PRESCALE) begin
            src      = SRC_PRESCALE;
            mmio_val = mm_prescale;
        end else if (address == A_EDGE) begin
            src      = SRC_EDGE;
            mmio_val = edge_q;
        end else if (address == A_IRQEN) begin
            src      = SRC_IRQEN;
            mmio_val = irq_en;
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (address == ADDR_W'(TOP - OFS_IN_BASE - i)) begin
                    src      = SRC_IN;
                    mmio_val = sync2[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_prev    <= '0;
            edge_q      <= '0;
            irq_en      <= '0;
            mm_prescale <= '0;
            irq         <= 1'b0;
            rd_valid    <= 1'b0;
            src_q       <= SRC_RAM;
            mmio_q      <= '0;
            hold_q      <= '0;
        end else begin
            sync1    <= in_bus;
            sync2    <= sync1;
            btn_prev <= sync2[EDGE_PORT*DATA_W +: DATA_W];
            if (write && address == A_PRESCALE) mm_prescale <= mem_di;
            if (write && address == A_IRQEN)    irq_en      <= mem_di;
            // New edges are OR-ed in after the clear so a coincident event survives.
            if (write && address == A_EDGE) edge_q <= (edge_q & ~mem_di) | rise;
            else                            edge_q <= edge_q | rise;
            irq      <= |(edge_q & irq_en);
            rd_valid <= rd_acc;
            if (rd_acc) begin
                src_q  <= src;
                mmio_q <= mmio_val;
            end
            hold_q <= mem_do;
        end
    end

    // MMIO data is captured at the read edge; RAM data arrives from the array register.
    assign mem_do = rd_valid ? ((src_q == SRC_RAM) ? ram_dout : mmio_q) : hold_q;

endmodule

// File: tb/tb_mmio_ram_v2.sv
// Self-checking bench for mmio_ram_v2 with a behavioural register/RAM model.
module tb_mmio_ram_v2;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int NI = 3;
    localparam logic [AW-1:0] A_PRE   = 15'h7FFF;
    localparam logic [AW-1:0] A_IN1   = 15'h7FFD;
    localparam logic [AW-1:0] A_EDGE  = 15'h7FFB;
    localparam logic [AW-1:0] A_IRQEN = 15'h7FFA;

    logic              mem_clk = 1'b0;
    logic              mem_reset, read, write;
    logic [AW-1:0]     address;
    logic [DW-1:0]     mem_di;
    logic [NI*DW-1:0]  in_bus;
    logic [DW-1:0]     mem_do, mm_prescale;
    logic              rd_valid, irq;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ram_m [int];
    logic [DW-1:0] pre_m, irqen_m, exp_do;
    logic          watch = 1'b0, saw_rv = 1'b0;

    mmio_ram_v2 #(.ADDR_W(AW), .DATA_W(DW), .N_IN(NI), .EDGE_PORT(NI-1)) dut (
        .mem_clk    (mem_clk),
        .mem_reset  (mem_reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .mem_di     (mem_di),
        .in_bus     (in_bus),
        .mem_do     (mem_do),
        .rd_valid   (rd_valid),
        .mm_prescale(mm_prescale),
        .irq        (irq)
    );

    always #5 mem_clk = ~mem_clk;

    always @(rd_valid) if (watch && rd_valid === 1'b1) saw_rv = 1'b1;

    task automatic step;
        @(posedge mem_clk);
        #1;
    endtask

    task automatic test_reset;
        mem_reset = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; mem_di = '0; in_bus = '0;
        step; step;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %h want 0", rd_valid); end
        checks++; if (mem_do !== 8'h00) begin errors++; $display("FAIL reset_mem_do got %h want 00", mem_do); end
        checks++; if (mm_prescale !== 8'h00) begin errors++; $display("FAIL reset_prescale got %h want 00", mm_prescale); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %h want 0", irq); end
        mem_reset = 1'b0;
        pre_m = 8'h00; irqen_m = 8'h00; exp_do = 8'h00;
        step;
    endtask

    task automatic test_ram_basic;
        write = 1'b1; address = 15'h0010; mem_di = 8'hA5; ram_m[16] = 8'hA5;
        step;
        write = 1'b0; read = 1'b1;
        step;
        read = 1'b0; exp_do = 8'hA5;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL ram_rd_valid got %h want 1", rd_valid); end
        checks++; if (mem_do !== exp_do) begin errors++; $display("FAIL ram_read got %h want %h", mem_do, exp_do); end
        step;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ram_rd_valid_pulse got %h want 0", rd_valid); end
        checks++; if (mem_do !== exp_do) begin errors++; $display("FAIL ram_hold got %h want %h", mem_do, exp_do); end
    endtask

    task automatic test_prescale;
        write = 1'b1; address = A_PRE; mem_di = 8'h3C; pre_m = 8'h3C;
        step;
        write = 1'b0;
        checks++; if (mm_prescale !== pre_m) begin errors++; $display("FAIL prescale_out got %h want %h", mm_prescale, pre_m); end
        read = 1'b1;
        step;
        read = 1'b0; exp_do = pre_m;
        checks++; if (mem_do !== exp_do || rd_valid !== 1'b1) begin errors++; $display("FAIL prescale_read got %h/%h want %h/1", mem_do, rd_valid, exp_do); end
        checks++; if (dut.u_ram.mem[15'h7FFF] === 8'h3C) begin errors++; $display("FAIL prescale_shadow got %h want not 3c", dut.u_ram.mem[15'h7FFF]); end
    endtask

    task automatic test_in_sync;
        logic [DW-1:0] want [3];
        want[0] = 8'h00; want[1] = 8'h00; want[2] = 8'h5A;
        in_bus = '0; in_bus[DW +: DW] = 8'h5A;
        read = 1'b1; address = A_IN1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (mem_do !== want[i] || rd_valid !== 1'b1) begin errors++; $display("FAIL in_sync_%0d got %h/%h want %h/1", i, mem_do, rd_valid, want[i]); end
        end
        read = 1'b0; write = 1'b1; mem_di = 8'hFF;
        step;
        write = 1'b0; read = 1'b1;
        step;
        read = 1'b0; exp_do = 8'h5A;
        checks++; if (mem_do !== exp_do) begin errors++; $display("FAIL in_ro got %h want %h", mem_do, exp_do); end
    endtask

    task automatic test_random;
        int unsigned op;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        logic exp_rv;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 5);
            a = AW'(32'h100 + $urandom_range(0, 15));
            v = DW'($urandom);
            read = 1'b0; write = 1'b0; exp_rv = 1'b0;
            case (op)
                0: begin write = 1'b1; address = a; mem_di = v; ram_m[int'(a)] = v; end
                1: if (ram_m.exists(int'(a))) begin
                       read = 1'b1; address = a; exp_rv = 1'b1; exp_do = ram_m[int'(a)];
                   end
                2: begin
                       write = 1'b1; mem_di = v;
                       if ($urandom_range(0, 1) == 0) begin address = A_PRE; pre_m = v; end
                       else begin address = A_IRQEN; irqen_m = v; end
                   end
                3: begin
                       read = 1'b1; exp_rv = 1'b1;
                       if ($urandom_range(0, 1) == 0) begin address = A_PRE; exp_do = pre_m; end
                       else begin address = A_IRQEN; exp_do = irqen_m; end
                   end
                4: begin read = 1'b1; write = 1'b1; address = a; mem_di = v; ram_m[int'(a)] = v; end
                default: ;
            endcase
            step;
            checks++; if (rd_valid !== exp_rv) begin errors++; $display("FAIL rand_rd_valid[%0d] got %h want %h", n, rd_valid, exp_rv); end
            checks++; if (mem_do !== exp_do) begin errors++; $display("FAIL rand_mem_do[%0d] got %h want %h", n, mem_do, exp_do); end
            checks++; if (mm_prescale !== pre_m) begin errors++; $display("FAIL rand_prescale[%0d] got %h want %h", n, mm_prescale, pre_m); end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rand_irq[%0d] got %h want 0", n, irq); end
        end
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] v20, v21;
        v20 = DW'($urandom); v21 = DW'($urandom);
        write = 1'b1; address = 15'h0021; mem_di = v21;
        step;
        read = 1'b1; address = 15'h0020; mem_di = v20;
        step;
        write = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rw_same_no_valid got %h want 0", rd_valid); end
        step;
        checks++; if (mem_do !== v20 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_0020 got %h/%h want %h/1", mem_do, rd_valid, v20); end
        address = 15'h0021;
        step;
        read = 1'b0;
        checks++; if (mem_do !== v21 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_0021 got %h/%h want %h/1", mem_do, rd_valid, v21); end
        step;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %h want 0", rd_valid); end
    endtask

    task automatic test_edge;
        write = 1'b1; address = A_IRQEN; mem_di = 8'h01;
        step;
        write = 1'b0;
        in_bus[2*DW] = 1'b1;
        step; step; step;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got %h want 0", irq); end
        step;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq got %h want 1", irq); end
        read = 1'b1; address = A_EDGE;
        step;
        read = 1'b0;
        checks++; if (mem_do !== 8'h01) begin errors++; $display("FAIL edge_flag got %h want 01", mem_do); end
        write = 1'b1; mem_di = 8'h01;
        step;
        write = 1'b0;
        step;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_clear_irq got %h want 0", irq); end
        read = 1'b1;
        step;
        read = 1'b0;
        checks++; if (mem_do !== 8'h00) begin errors++; $display("FAIL edge_cleared got %h want 00", mem_do); end
        in_bus[2*DW] = 1'b0;
        step; step; step; step;
        in_bus[2*DW] = 1'b1;
        step; step;
        write = 1'b1; address = A_EDGE; mem_di = 8'h01;
        step;
        write = 1'b0; read = 1'b1;
        step;
        read = 1'b0;
        checks++; if (mem_do !== 8'h01) begin errors++; $display("FAIL edge_set_wins got %h want 01", mem_do); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_set_wins_irq got %h want 1", irq); end
    endtask

    task automatic test_reset_mid_read;
        write = 1'b1; address = A_PRE; mem_di = 8'h77;
        step;
        write = 1'b0; in_bus = '0;
        read = 1'b1; address = 15'h0020; saw_rv = 1'b0; watch = 1'b1;
        #4 mem_reset = 1'b1;
        @(posedge mem_clk); #1;
        read = 1'b0;
        step;
        watch = 1'b0;
        checks++; if (saw_rv !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got %h want 0", saw_rv); end
        checks++; if (mm_prescale !== 8'h00) begin errors++; $display("FAIL rst_mid_prescale got %h want 00", mm_prescale); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %h want 0", irq); end
        checks++; if (mem_do !== 8'h00) begin errors++; $display("FAIL rst_mid_mem_do got %h want 00", mem_do); end
        mem_reset = 1'b0;
        step;
        read = 1'b1; address = A_EDGE;
        step;
        read = 1'b0;
        checks++; if (mem_do !== 8'h00 || rd_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_edge got %h/%h want 00/1", mem_do, rd_valid); end
    endtask

    initial begin
        test_reset;
        test_ram_basic;
        test_prescale;
        test_in_sync;
        test_random;
        test_back_to_back;
        test_edge;
        test_reset_mid_read;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
